// File: rtl/riscv_32_pipe_ctrl.sv
// Pipeline controller for the 3-stage RV32 core: stage enables, redirect bubbles,
// WB->EX forwarding selects, divider start/done handshake and debug stall/flush counters.
module riscv_32_pipe_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      ex_instr,
   input  logic             branch_taken,
   input  logic             wb_regwrite,
   input  logic [4:0]       wb_rd,
   input  logic             div_done,
   output logic             pc_en,
   output logic             pc_sel,
   output logic             if_ex_en,
   output logic             ex_bubble,
   output logic             ex_valid,
   output logic             wb_en,
   output logic             fwd_rs1,
   output logic             fwd_rs2,
   output logic             div_start,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      DIV_WAIT = 2'd2
   } state_e;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   state_e           state_q, state_d, cur_state;
   logic             ex_valid_q, ex_valid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [6:0] opcode;
   logic [4:0] rs1, rs2;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       is_jump, is_branch, is_div;
   logic       redirect, div_req;
   logic       stall_inc, flush_inc;

   assign opcode = ex_instr[6:0];
   assign funct3 = ex_instr[14:12];
   assign rs1    = ex_instr[19:15];
   assign rs2    = ex_instr[24:20];
   assign funct7 = ex_instr[31:25];

   assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_div    = (opcode == OP_REG) && (funct7 == F7_MULDIV) && funct3[2];

   // A bubble in EX must never redirect or start the divider, whatever its bits look like.
   assign redirect = ex_valid_q && (is_jump || (is_branch && branch_taken));
   assign div_req  = ex_valid_q && is_div;

   assign fwd_rs1 = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs1);
   assign fwd_rs2 = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs2);

   assign cur_state = rst ? BOOT : state_q;

   always_comb begin
      state_d   = state_q;
      pc_en     = 1'b0;
      pc_sel    = 1'b0;
      if_ex_en  = 1'b0;
      ex_bubble = 1'b0;
      wb_en     = 1'b0;
      div_start = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      case (cur_state)
         BOOT: begin
            pc_en     = 1'b1;
            if_ex_en  = 1'b1;
            ex_bubble = 1'b1;
            wb_en     = 1'b1;
            state_d   = RUN;
         end
         RUN: begin
            if (div_req) begin
               div_start = 1'b1;
               state_d   = DIV_WAIT;
            end else begin
               pc_en     = 1'b1;
               if_ex_en  = 1'b1;
               wb_en     = 1'b1;
               pc_sel    = redirect;
               ex_bubble = redirect;
               flush_inc = redirect;
            end
         end
         DIV_WAIT: begin
            if (div_done) begin
               pc_en    = 1'b1;
               if_ex_en = 1'b1;
               wb_en    = 1'b1;
               state_d  = RUN;
            end else begin
               stall_inc = 1'b1;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      ex_valid_d  = if_ex_en ? ~ex_bubble : ex_valid_q;
      stall_cnt_d = (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= BOOT;
         ex_valid_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ex_valid_q  <= ex_valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ex_valid  = ex_valid_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_riscv_32_pipe_ctrl.sv
// Bench for riscv_32_pipe_ctrl: cycle vector table through a scoreboard queue, plus
// hand-written redirect-saturation and divider-latency sequences.
module tb_riscv_32_pipe_ctrl;

   localparam logic [31:0] NOP    = 32'h00000013;
   localparam logic [31:0] BEQ    = 32'h00208063; // beq x1, x2
   localparam logic [31:0] JAL    = 32'h000000EF; // jal x1, 0
   localparam logic [31:0] JALR   = 32'h00008067; // jalr x0, 0(x1)
   localparam logic [31:0] DIV    = 32'h0220C1B3; // div x3, x1, x2
   localparam logic [31:0] DIVX0  = 32'h0220C033; // div x0, x1, x2
   localparam logic [31:0] MUL    = 32'h022081B3; // mul x3, x1, x2
   localparam logic [31:0] ADD755 = 32'h005283B3; // add x7, x5, x5
   localparam logic [31:0] ADD705 = 32'h005003B3; // add x7, x0, x5

   // flags = {pc_en, pc_sel, if_ex_en, ex_bubble, ex_valid, wb_en, fwd_rs1, fwd_rs2, div_start}
   localparam logic [8:0] F_BOOT0 = 9'b101101000;
   localparam logic [8:0] F_BOOT1 = 9'b101111000;
   localparam logic [8:0] F_RUN0  = 9'b101001000;
   localparam logic [8:0] F_RUN1  = 9'b101011000;
   localparam logic [8:0] F_RED   = 9'b111111000;
   localparam logic [8:0] F_DSTRT = 9'b000010001;
   localparam logic [8:0] F_DWAIT = 9'b000010000;

   typedef struct packed {
      logic [8:0]  flags;
      logic [15:0] stall;
      logic [15:0] flush;
   } exp_t;

   typedef struct {
      logic        rst;
      logic [31:0] ins;
      logic        tk;
      logic        wr;
      logic [4:0]  rd;
      logic        dn;
      exp_t        e;
   } vec_t;

   localparam int NV = 37;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ex_instr;
   logic        branch_taken, wb_regwrite, div_done;
   logic [4:0]  wb_rd;

   logic        pc_en, pc_sel, if_ex_en, ex_bubble, ex_valid, wb_en;
   logic        fwd_rs1, fwd_rs2, div_start;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_pc_en, s_pc_sel, s_if_ex_en, s_ex_bubble, s_ex_valid, s_wb_en;
   logic        s_fwd_rs1, s_fwd_rs2, s_div_start;
   logic [1:0]  s_stall_cnt, s_flush_cnt;

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[NV];
   vec_t sb_q[$];

   always #5 clk = ~clk;

   riscv_32_pipe_ctrl dut (
      .clk(clk), .rst(rst), .ex_instr(ex_instr), .branch_taken(branch_taken),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .div_done(div_done),
      .pc_en(pc_en), .pc_sel(pc_sel), .if_ex_en(if_ex_en), .ex_bubble(ex_bubble),
      .ex_valid(ex_valid), .wb_en(wb_en), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .div_start(div_start), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   riscv_32_pipe_ctrl #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .ex_instr(ex_instr), .branch_taken(branch_taken),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .div_done(div_done),
      .pc_en(s_pc_en), .pc_sel(s_pc_sel), .if_ex_en(s_if_ex_en), .ex_bubble(s_ex_bubble),
      .ex_valid(s_ex_valid), .wb_en(s_wb_en), .fwd_rs1(s_fwd_rs1), .fwd_rs2(s_fwd_rs2),
      .div_start(s_div_start), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   function automatic vec_t mk(input logic r, input logic [31:0] ins, input logic tk,
                               input logic wr, input logic [4:0] rd, input logic dn,
                               input logic [8:0] f, input int st, input int fl);
      vec_t v;
      v.rst = r; v.ins = ins; v.tk = tk; v.wr = wr; v.rd = rd; v.dn = dn;
      v.e.flags = f;
      v.e.stall = st[15:0];
      v.e.flush = fl[15:0];
      return v;
   endfunction

   function automatic logic [1:0] sat2(input logic [15:0] x);
      return (x > 16'd3) ? 2'd3 : x[1:0];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [31:0] ins, input logic tk,
                       input logic wr, input logic [4:0] rd, input logic dn);
      @(posedge clk);
      #1;
      rst = r; ex_instr = ins; branch_taken = tk; wb_regwrite = wr; wb_rd = rd; div_done = dn;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t cur;
      exp_t act;
      int   ds_n, pc_low;
      logic done_pc;

      rst = 1'b1; ex_instr = NOP; branch_taken = 1'b0; wb_regwrite = 1'b0; wb_rd = 5'd0; div_done = 1'b0;

      tbl[0]  = mk(1, NOP,    0, 0, 0, 0, F_BOOT0, 0, 0);
      tbl[1]  = mk(1, NOP,    0, 0, 0, 0, F_BOOT0, 0, 0);
      tbl[2]  = mk(0, NOP,    0, 0, 0, 0, F_BOOT0, 0, 0);
      tbl[3]  = mk(0, NOP,    0, 0, 0, 0, F_RUN0,  0, 0);
      tbl[4]  = mk(0, NOP,    0, 0, 0, 0, F_RUN1,  0, 0);
      tbl[5]  = mk(0, BEQ,    0, 0, 0, 0, F_RUN1,  0, 0);
      tbl[6]  = mk(0, BEQ,    1, 0, 0, 0, F_RED,   0, 0);
      tbl[7]  = mk(0, BEQ,    1, 0, 0, 0, F_RUN0,  0, 1);
      tbl[8]  = mk(0, NOP,    0, 0, 0, 0, F_RUN1,  0, 1);
      tbl[9]  = mk(0, JAL,    0, 0, 0, 0, F_RED,   0, 1);
      tbl[10] = mk(0, NOP,    0, 0, 0, 0, F_RUN0,  0, 2);
      tbl[11] = mk(0, JALR,   1, 0, 0, 0, F_RED,   0, 2);
      tbl[12] = mk(0, NOP,    0, 0, 0, 0, F_RUN0,  0, 3);
      tbl[13] = mk(0, NOP,    0, 0, 0, 0, F_RUN1,  0, 3);
      tbl[14] = mk(0, MUL,    0, 0, 0, 0, F_RUN1,  0, 3);
      tbl[15] = mk(0, DIV,    0, 0, 0, 1, F_DSTRT, 0, 3);
      tbl[16] = mk(0, DIV,    0, 0, 0, 0, F_DWAIT, 0, 3);
      tbl[17] = mk(0, DIV,    0, 0, 0, 0, F_DWAIT, 1, 3);
      tbl[18] = mk(0, DIV,    0, 0, 0, 0, F_DWAIT, 2, 3);
      tbl[19] = mk(0, DIV,    0, 0, 0, 1, F_RUN1,  3, 3);
      tbl[20] = mk(0, NOP,    0, 0, 0, 0, F_RUN1,  3, 3);
      tbl[21] = mk(0, NOP,    0, 0, 0, 1, F_RUN1,  3, 3);
      tbl[22] = mk(0, DIVX0,  0, 0, 0, 0, F_DSTRT, 3, 3);
      tbl[23] = mk(0, DIVX0,  0, 0, 0, 0, F_DWAIT, 3, 3);
      tbl[24] = mk(0, DIVX0,  0, 0, 0, 1, F_RUN1,  4, 3);
      tbl[25] = mk(0, ADD755, 0, 1, 5, 0, 9'b101011110, 4, 3);
      tbl[26] = mk(0, ADD755, 0, 0, 5, 0, F_RUN1,  4, 3);
      tbl[27] = mk(0, ADD705, 0, 1, 0, 0, F_RUN1,  4, 3);
      tbl[28] = mk(0, BEQ,    0, 1, 2, 0, 9'b101011010, 4, 3);
      tbl[29] = mk(0, JALR,   0, 1, 1, 0, 9'b111111100, 4, 3);
      tbl[30] = mk(0, DIV,    0, 1, 1, 0, 9'b101001100, 4, 4);
      tbl[31] = mk(0, DIV,    0, 0, 0, 0, F_DSTRT, 4, 4);
      tbl[32] = mk(0, DIV,    0, 0, 0, 0, F_DWAIT, 4, 4);
      tbl[33] = mk(1, DIV,    0, 0, 0, 0, F_BOOT1, 5, 4);
      tbl[34] = mk(0, NOP,    0, 0, 0, 0, F_BOOT0, 0, 0);
      tbl[35] = mk(0, NOP,    0, 0, 0, 0, F_RUN0,  0, 0);
      tbl[36] = mk(0, NOP,    0, 0, 0, 0, F_RUN1,  0, 0);

      @(posedge clk);
      for (int i = 0; i < NV; i++) begin
         sb_q.push_back(tbl[i]);
         step(tbl[i].rst, tbl[i].ins, tbl[i].tk, tbl[i].wr, tbl[i].rd, tbl[i].dn);
         cur = sb_q.pop_front();
         act.flags = {pc_en, pc_sel, if_ex_en, ex_bubble, ex_valid, wb_en, fwd_rs1, fwd_rs2, div_start};
         act.stall = stall_cnt;
         act.flush = flush_cnt;
         chk($sformatf("vec%0d", i), 64'(act), 64'(cur.e));
         chk($sformatf("vec%0d_sat_cnt", i), 64'({s_stall_cnt, s_flush_cnt}),
             64'({sat2(cur.e.stall), sat2(cur.e.flush)}));
      end

      // Five redirects: the 2-bit counter pins at 3 while the wide one reaches 5.
      for (int k = 0; k < 5; k++) begin
         step(0, JAL, 0, 0, 0, 0);
         chk($sformatf("sat_jal%0d_pc_sel", k), 64'(pc_sel), 64'd1);
         step(0, NOP, 0, 0, 0, 0);
      end
      step(0, NOP, 0, 0, 0, 0);
      chk("sat_flush_wide", 64'(flush_cnt), 64'd5);
      chk("sat_flush_2bit", 64'(s_flush_cnt), 64'd3);

      // Divider with done four cycles after start.
      ds_n = 0; pc_low = 0; done_pc = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step(0, (c < 5) ? DIV : NOP, 0, 0, 0, (c == 4));
         if (div_start) ds_n++;
         if (!pc_en) pc_low++;
         if (c == 4) done_pc = pc_en;
      end
      chk("div_start_pulses", 64'(ds_n), 64'd1);
      chk("div_pc_en_low_cycles", 64'(pc_low), 64'd4);
      chk("div_pc_en_done_cycle", 64'(done_pc), 64'd1);
      chk("div_stall_cnt", 64'(stall_cnt), 64'd3);
      chk("div_stall_cnt_2bit", 64'(s_stall_cnt), 64'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
